// File: rtl/mem_access_stage.sv
// -----------------------------------------------------------------------------
// mem_access_stage
//   Consumer side of the EX/MEM pipeline register. Performs the single data
//   memory transaction of a load/store over a req/ack handshake, stalls the
//   upstream pipeline while that transaction is outstanding, and drives the
//   single register-file writeback port (ALU result, loaded data, or the
//   updated base register).
//
// Optional feature macro: MEM_TIMEOUT_EN
//   Defined   -> REQ gives up after TIMEOUT_CYCLES cycles without ack,
//                pulses mem_fault for one cycle and performs no writeback.
//   Undefined -> REQ waits for ack indefinitely; mem_fault is tied 0.
//
// Ports
//   clk, reset         clock; synchronous active-high reset
//   valid_in .. alu_result_in   registered EX/MEM fields (sampled in IDLE only)
//   stall_o            hold EX/MEM contents (state != IDLE)
//   dmem_req/we/addr/be/wdata   data memory request side
//   dmem_ack/rdata     data memory response (rdata valid with ack)
//   wb_valid/wb_rd/wb_data      register-file writeback, one cycle per write
//   mem_fault          one-cycle timeout pulse
//
// Handshake: dmem_req is high for every cycle the FSM sits in REQ, and all
// dmem_* request fields stay constant during that time. A transfer completes
// on the first rising edge where dmem_req and dmem_ack are both high;
// dmem_rdata is taken on that same edge. dmem_req drops on the following
// cycle, so back-to-back accesses are always separated by an IDLE cycle.
// dmem_ack seen outside REQ is ignored.
// -----------------------------------------------------------------------------
module mem_access_stage #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_in,
  input  logic        mem_en_in,
  input  logic        load_store_in,
  input  logic        byte_word_in,
  input  logic        pre_post_in,
  input  logic        write_back_in,
  input  logic        reg_write_in,
  input  logic [3:0]  rd_in,
  input  logic [3:0]  rn_in,
  input  logic [31:0] base_in,
  input  logic [31:0] addr_final_in,
  input  logic [31:0] store_data_in,
  input  logic [31:0] alu_result_in,
  output logic        stall_o,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        wb_valid,
  output logic [3:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        mem_fault
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_BASE = 2'd2
  } state_e;

  // state_q is the FSM state visible to checkers
  state_e      state_q, state_d;

  // Latched transaction fields
  logic        load_q, load_d;
  logic        byte_q, byte_d;
  logic        wbk_q, wbk_d;
  logic [3:0]  rd_q, rd_d;
  logic [3:0]  rn_q, rn_d;
  logic [31:0] ea_q, ea_d;
  logic [31:0] af_q, af_d;
  logic [31:0] sd_q, sd_d;

  // Writeback / fault registers
  logic        wb_valid_q, wb_valid_d;
  logic [3:0]  wb_rd_q, wb_rd_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic        mem_fault_q, mem_fault_d;

  logic        launch;
  logic        timeout;
  logic [31:0] rdata_shift;

  assign launch = valid_in && mem_en_in;

`ifdef MEM_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  logic [CW-1:0] cnt_q, cnt_d;

  // Fires on the TIMEOUT_CYCLES-th REQ cycle without ack; ack wins on that cycle.
  assign timeout = (state_q == ST_REQ) && !dmem_ack &&
                   (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == ST_IDLE && launch)        cnt_d = '0;
    else if (state_q == ST_REQ && !dmem_ack) cnt_d = cnt_q + 1'b1;
  end
`else
  logic [31:0] timeout_unused;
  assign timeout_unused = 32'(TIMEOUT_CYCLES);
  assign timeout        = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // State and data registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      load_q      <= 1'b0;
      byte_q      <= 1'b0;
      wbk_q       <= 1'b0;
      rd_q        <= '0;
      rn_q        <= '0;
      ea_q        <= '0;
      af_q        <= '0;
      sd_q        <= '0;
      wb_valid_q  <= 1'b0;
      wb_rd_q     <= '0;
      wb_data_q   <= '0;
      mem_fault_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      load_q      <= load_d;
      byte_q      <= byte_d;
      wbk_q       <= wbk_d;
      rd_q        <= rd_d;
      rn_q        <= rn_d;
      ea_q        <= ea_d;
      af_q        <= af_d;
      sd_q        <= sd_d;
      wb_valid_q  <= wb_valid_d;
      wb_rd_q     <= wb_rd_d;
      wb_data_q   <= wb_data_d;
      mem_fault_q <= mem_fault_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (launch) state_d = ST_REQ;
      ST_REQ: begin
        if (dmem_ack) begin
          // A load into the base register keeps the loaded value; the base
          // update is dropped.
          if (load_q) state_d = (wbk_q && (rn_q != rd_q)) ? ST_BASE : ST_IDLE;
          else        state_d = wbk_q ? ST_BASE : ST_IDLE;
        end else if (timeout) begin
          state_d = ST_IDLE;
        end
      end
      ST_BASE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output / datapath logic
  // ---------------------------------------------------------------------------
  assign rdata_shift = dmem_rdata >> {ea_q[1:0], 3'b000};

  always_comb begin
    load_d      = load_q;
    byte_d      = byte_q;
    wbk_d       = wbk_q;
    rd_d        = rd_q;
    rn_d        = rn_q;
    ea_d        = ea_q;
    af_d        = af_q;
    sd_d        = sd_q;
    wb_valid_d  = 1'b0;
    wb_rd_d     = wb_rd_q;
    wb_data_d   = wb_data_q;
    mem_fault_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (launch) begin
          load_d = load_store_in;
          byte_d = byte_word_in;
          wbk_d  = write_back_in;
          rd_d   = rd_in;
          rn_d   = rn_in;
          ea_d   = pre_post_in ? addr_final_in : base_in;
          af_d   = addr_final_in;
          sd_d   = store_data_in;
        end else if (valid_in && reg_write_in) begin
          wb_valid_d = 1'b1;
          wb_rd_d    = rd_in;
          wb_data_d  = alu_result_in;
        end
      end
      ST_REQ: begin
        if (dmem_ack && load_q) begin
          wb_valid_d = 1'b1;
          wb_rd_d    = rd_q;
          wb_data_d  = byte_q ? {24'h0, rdata_shift[7:0]} : dmem_rdata;
        end
        mem_fault_d = timeout;
      end
      ST_BASE: begin
        wb_valid_d = 1'b1;
        wb_rd_d    = rn_q;
        wb_data_d  = af_q;
      end
      default: ;
    endcase
  end

  // Memory request fields are decoded from registered state, so they are
  // glitch-free and constant for the whole REQ residency.
  always_comb begin
    stall_o    = (state_q != ST_IDLE);
    dmem_req   = (state_q == ST_REQ);
    dmem_we    = 1'b0;
    dmem_addr  = '0;
    dmem_be    = '0;
    dmem_wdata = '0;
    if (dmem_req) begin
      dmem_we    = !load_q;
      dmem_addr  = {ea_q[31:2], 2'b00};
      dmem_be    = byte_q ? (4'b0001 << ea_q[1:0]) : 4'hF;
      dmem_wdata = byte_q ? {4{sd_q[7:0]}} : sd_q;
    end
  end

  assign wb_valid  = wb_valid_q;
  assign wb_rd     = wb_rd_q;
  assign wb_data   = wb_data_q;
  assign mem_fault = mem_fault_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_access_stage
//   Self-checking bench for mem_access_stage. Expected writebacks are queued
//   when an operation is issued and compared in order by a monitor whenever
//   wb_valid is seen. Request-side fields are checked every REQ cycle.
// -----------------------------------------------------------------------------
module tb_mem_access_stage;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_in, mem_en_in, load_store_in, byte_word_in, pre_post_in;
  logic        write_back_in, reg_write_in;
  logic [3:0]  rd_in, rn_in;
  logic [31:0] base_in, addr_final_in, store_data_in, alu_result_in;
  logic        stall_o, dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        wb_valid;
  logic [3:0]  wb_rd;
  logic [31:0] wb_data;
  logic        mem_fault;

  int vectors = 0;
  int errors  = 0;
  logic [35:0] exp_q[$];

  mem_access_stage #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset),
    .valid_in(valid_in), .mem_en_in(mem_en_in), .load_store_in(load_store_in),
    .byte_word_in(byte_word_in), .pre_post_in(pre_post_in),
    .write_back_in(write_back_in), .reg_write_in(reg_write_in),
    .rd_in(rd_in), .rn_in(rn_in), .base_in(base_in),
    .addr_final_in(addr_final_in), .store_data_in(store_data_in),
    .alu_result_in(alu_result_in), .stall_o(stall_o),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .wb_data(wb_data), .mem_fault(mem_fault)
  );

  // ---------------------------------------------------------------------------
  // Clock
  // ---------------------------------------------------------------------------
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Checker
  // ---------------------------------------------------------------------------
  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every writeback must match the oldest expectation.
  always @(negedge clk) begin
    if (wb_valid === 1'b1) begin
      if (exp_q.size() == 0) check("wb_unexpected", {31'h0, wb_valid}, 64'h0);
      else                   check("wb_data", {28'h0, wb_rd, wb_data}, {28'h0, exp_q.pop_front()});
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic idle_inputs();
    valid_in = 0; mem_en_in = 0; load_store_in = 0; byte_word_in = 0;
    pre_post_in = 0; write_back_in = 0; reg_write_in = 0;
    rd_in = 0; rn_in = 0; base_in = 0; addr_final_in = 0;
    store_data_in = 0; alu_result_in = 0;
  endtask

  // Fields change while stalled; the DUT must have latched the originals.
  task automatic scramble_inputs();
    load_store_in = 1'($urandom); byte_word_in = 1'($urandom);
    pre_post_in = 1'($urandom); write_back_in = 1'($urandom);
    rd_in = 4'($urandom); rn_in = 4'($urandom);
    base_in = $urandom; addr_final_in = $urandom; store_data_in = $urandom;
  endtask

  task automatic alu_op(input logic rw, input logic [3:0] rd, input logic [31:0] res);
    @(posedge clk); #1;
    valid_in = 1; mem_en_in = 0; reg_write_in = rw; rd_in = rd; alu_result_in = res;
    if (rw) exp_q.push_back({rd, res});
    @(negedge clk);
    check("alu_stall", {63'h0, stall_o}, 64'h0);
    @(posedge clk); #1;
    valid_in = 0; reg_write_in = 0;
    @(negedge clk);
    check("alu_wb_valid", {63'h0, wb_valid}, {63'h0, rw});
    check("alu_stall_after", {63'h0, stall_o}, 64'h0);
  endtask

  task automatic mem_access(input logic ld, input logic byt, input logic pre,
                            input logic wbk, input logic [3:0] rd, input logic [3:0] rn,
                            input logic [31:0] base, input logic [31:0] af,
                            input logic [31:0] sd, input logic [31:0] rdata,
                            input int lat);
    logic [31:0] ea, e_addr, e_wdata, e_ld;
    logic [3:0]  e_be;
    logic        to_base;
    ea      = pre ? af : base;
    e_addr  = {ea[31:2], 2'b00};
    case (ea[1:0])
      2'd0: begin e_be = 4'b0001; e_ld = {24'h0, rdata[7:0]};   end
      2'd1: begin e_be = 4'b0010; e_ld = {24'h0, rdata[15:8]};  end
      2'd2: begin e_be = 4'b0100; e_ld = {24'h0, rdata[23:16]}; end
      default: begin e_be = 4'b1000; e_ld = {24'h0, rdata[31:24]}; end
    endcase
    if (!byt) begin e_be = 4'hF; e_ld = rdata; end
    e_wdata = byt ? {sd[7:0], sd[7:0], sd[7:0], sd[7:0]} : sd;
    to_base = wbk && !(ld && (rn == rd));
    if (ld)      exp_q.push_back({rd, e_ld});
    if (to_base) exp_q.push_back({rn, af});

    @(posedge clk); #1;
    valid_in = 1; mem_en_in = 1; reg_write_in = 0;
    load_store_in = ld; byte_word_in = byt; pre_post_in = pre; write_back_in = wbk;
    rd_in = rd; rn_in = rn; base_in = base; addr_final_in = af; store_data_in = sd;
    @(posedge clk); #1;
    scramble_inputs();
    valid_in = 0;
    for (int i = 0; i < lat; i++) begin
      @(negedge clk);
      check("req",   {63'h0, dmem_req}, 64'h1);
      check("stall", {63'h0, stall_o},  64'h1);
      check("we",    {63'h0, dmem_we},  {63'h0, !ld});
      check("addr",  {32'h0, dmem_addr},  {32'h0, e_addr});
      check("be",    {60'h0, dmem_be},    {60'h0, e_be});
      check("wdata", {32'h0, dmem_wdata}, {32'h0, e_wdata});
    end
    dmem_ack = 1; dmem_rdata = rdata;
    @(posedge clk); #1;
    dmem_ack = 0; dmem_rdata = $urandom;
    @(negedge clk);
    check("req_drop",   {63'h0, dmem_req},  64'h0);
    check("ld_wb_valid", {63'h0, wb_valid}, {63'h0, ld});
    check("base_stall", {63'h0, stall_o},   {63'h0, to_base});
    check("no_fault",   {63'h0, mem_fault}, 64'h0);
    if (to_base) begin
      @(negedge clk);
      check("base_wb_valid", {63'h0, wb_valid}, 64'h1);
      check("base_stall_end", {63'h0, stall_o}, 64'h0);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    reset = 1; dmem_ack = 0; dmem_rdata = 0;
    idle_inputs();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_stall", {63'h0, stall_o},   64'h0);
    check("rst_req",   {63'h0, dmem_req},  64'h0);
    check("rst_we",    {63'h0, dmem_we},   64'h0);
    check("rst_be",    {60'h0, dmem_be},   64'h0);
    check("rst_addr",  {32'h0, dmem_addr}, 64'h0);
    check("rst_wdata", {32'h0, dmem_wdata}, 64'h0);
    check("rst_wb",    {27'h0, wb_valid, wb_rd, wb_data}, 64'h0);
    check("rst_fault", {63'h0, mem_fault}, 64'h0);
    @(posedge clk); #1 reset = 0;

    // Directed cases
    alu_op(1'b1, 4'd3, 32'h1234);
    alu_op(1'b0, 4'd7, 32'hCAFE);                        // no writeback
    mem_access(1, 0, 1, 0, 4'd2, 4'd9, 32'h0, 32'h100, 32'h0, 32'hDEADBEEF, 3);
    mem_access(0, 1, 0, 1, 4'd6, 4'd4, 32'h203, 32'h207, 32'hAB, 32'h0, 2);
    mem_access(1, 1, 1, 1, 4'd1, 4'd5, 32'h2FE, 32'h302, 32'h0, 32'h11223344, 1);
    mem_access(1, 1, 1, 1, 4'd1, 4'd1, 32'h2FE, 32'h302, 32'h0, 32'h11223344, 2);
    mem_access(0, 0, 1, 0, 4'd0, 4'd0, 32'h0, 32'h404, 32'h87654321, 32'h0, TMO);
    mem_access(1, 1, 0, 0, 4'd8, 4'd0, 32'h501, 32'h0, 32'h0, 32'hA5B6C7D8, TMO);

    // Reset in REQ before ack, then a late ack
    @(posedge clk); #1;
    valid_in = 1; mem_en_in = 1; load_store_in = 1; byte_word_in = 0;
    pre_post_in = 1; write_back_in = 1; rd_in = 4'd2; rn_in = 4'd3;
    addr_final_in = 32'h600;
    @(posedge clk); #1 valid_in = 0;
    @(negedge clk);
    check("rst_mid_req_before", {63'h0, dmem_req}, 64'h1);
    @(posedge clk); #1 reset = 1;
    @(posedge clk); #1 reset = 0;
    @(negedge clk);
    check("rst_mid_req",   {63'h0, dmem_req},  64'h0);
    check("rst_mid_stall", {63'h0, stall_o},   64'h0);
    check("rst_mid_wb",    {63'h0, wb_valid},  64'h0);
    dmem_ack = 1; dmem_rdata = 32'h55AA55AA;
    @(posedge clk); #1 dmem_ack = 0;
    @(negedge clk);
    check("late_ack_stall", {63'h0, stall_o},  64'h0);
    check("late_ack_wb",    {63'h0, wb_valid}, 64'h0);
    check("late_ack_req",   {63'h0, dmem_req}, 64'h0);

`ifdef MEM_TIMEOUT_EN
    // No ack: gives up after TMO REQ cycles with a one-cycle fault pulse
    @(posedge clk); #1;
    valid_in = 1; mem_en_in = 1; load_store_in = 1; write_back_in = 1;
    pre_post_in = 1; rd_in = 4'd4; rn_in = 4'd6; addr_final_in = 32'h700;
    @(posedge clk); #1 valid_in = 0;
    for (int i = 0; i < TMO; i++) begin
      @(negedge clk);
      check("tmo_req",   {63'h0, dmem_req},  64'h1);
      check("tmo_nofault", {63'h0, mem_fault}, 64'h0);
    end
    @(negedge clk);
    check("tmo_fault", {63'h0, mem_fault}, 64'h1);
    check("tmo_req_drop", {63'h0, dmem_req}, 64'h0);
    check("tmo_stall", {63'h0, stall_o}, 64'h0);
    check("tmo_wb", {63'h0, wb_valid}, 64'h0);
    @(negedge clk);
    check("tmo_fault_pulse", {63'h0, mem_fault}, 64'h0);
    check("tmo_wb_after", {63'h0, wb_valid}, 64'h0);
`endif

    // Random mix
    for (int n = 0; n < 12; n++) begin
      if ($urandom_range(0, 2) == 0)
        alu_op(1'($urandom), 4'($urandom), $urandom);
      else
        mem_access(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                   4'($urandom), 4'($urandom), $urandom, $urandom, $urandom,
                   $urandom, $urandom_range(1, TMO));
    end

    repeat (3) @(negedge clk);
    check("sb_drain", 64'(exp_q.size()), 64'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  // Bound on total run time
  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Consumer side of the EX/MEM pipeline register. Takes the registered execute-stage outputs and performs the single data-memory transaction per load/store over a req/ack handshake.
- Stalls the upstream pipeline while the transaction is outstanding.
- Drives the single register-file writeback port: ALU result, loaded data, or updated base register.

Parameters:
- TIMEOUT_CYCLES, 16, ack wait limit in REQ; used only when MEM_TIMEOUT_EN is defined.

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- valid_in  in  1  EX/MEM entry holds a real instruction
- mem_en_in  in  1  instruction is load/store
- load_store_in  in  1  1=load, 0=store
- byte_word_in  in  1  1=byte, 0=word
- pre_post_in  in  1  1=pre-indexed, 0=post-indexed
- write_back_in  in  1  update base register
- reg_write_in  in  1  non-memory instruction writes rd
- rd_in  in  4  destination register
- rn_in  in  4  base register
- base_in  in  32  base register value
- addr_final_in  in  32  base ± offset
- store_data_in  in  32  store data
- alu_result_in  in  32  data-processing result
- stall_o  out  1  hold EX/MEM contents
- dmem_req  out  1  memory request
- dmem_we  out  1  1=write
- dmem_addr  out  32  word-aligned address
- dmem_be  out  4  byte enables
- dmem_wdata  out  32  write data
- dmem_ack  in  1  transaction complete; rdata valid same cycle
- dmem_rdata  in  32  read data
- wb_valid  out  1  writeback strobe, one cycle per write
- wb_rd  out  4  writeback register
- wb_data  out  32  writeback data
- mem_fault  out  1  timeout pulse

Behaviour:
- FSM states: IDLE, REQ, BASE. stall_o = (state != IDLE), decoded from registered state.
- Inputs are sampled only in IDLE; they are ignored in REQ and BASE. Upstream holds them while stall_o=1.
- IDLE, valid_in & mem_en_in:
  - Latch all fields; next state REQ.
  - Effective address = pre_post_in ? addr_final_in : base_in.
- IDLE, valid_in & !mem_en_in & reg_write_in:
  - Next edge: wb_valid=1, wb_rd=rd_in, wb_data=alu_result_in. Zero extra latency, no stall.
- IDLE, otherwise: wb_valid=0.
- REQ outputs:
  - dmem_req=1; dmem_addr={ea[31:2],2'b00}; dmem_we=!load.
  - Byte: dmem_be=1<<ea[1:0]; dmem_wdata={4{store_data[7:0]}}.
  - Word: dmem_be=4'hF; dmem_wdata=store_data.
  - All dmem outputs held constant until dmem_ack is sampled high.
- REQ, dmem_ack=1, load:
  - Next edge: wb_valid=1, wb_rd=rd.
  - wb_data = word ? dmem_rdata : zero-extended dmem_rdata[8*ea[1:0]+:8].
  - Next state BASE if write_back && rn!=rd, else IDLE. When rn==rd the loaded value wins and the base update is dropped.
- REQ, dmem_ack=1, store: next state BASE if write_back, else IDLE; wb_valid=0.
- BASE: wb_valid=1, wb_rd=rn, wb_data=addr_final (for both pre- and post-indexed); next state IDLE.
- dmem_req deasserts on the edge after ack. Back-to-back transactions have at least one IDLE cycle between them.
- dmem_ack outside REQ is ignored.
- Reset values: state=IDLE; stall_o, dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata, wb_valid, wb_rd, wb_data, mem_fault all 0.
- Reset mid-transaction: abandon the access, drop dmem_req next edge, no writeback.

Optional Feature:
- MEM_TIMEOUT_EN defined:
  - Counter clears on REQ entry and increments each REQ cycle without ack.
  - When the count reaches TIMEOUT_CYCLES: dmem_req drops, mem_fault pulses 1 cycle, no writeback (including base), state goes to IDLE.
  - Ack on the limit cycle takes priority over timeout.
- Undefined: REQ waits indefinitely; mem_fault is tied 0.

Test Plan:
- ALU op in IDLE: valid_in=1, mem_en_in=0, reg_write_in=1, rd=3, alu=0x1234 -> next cycle wb_valid=1, wb_rd=3, wb_data=0x1234; stall_o stays 0.
- Word load: ea=0x100, rd=2, ack after 3 cycles with rdata=0xDEADBEEF -> dmem_addr=0x100, be=F, we=0 held 3 cycles; then wb rd=2 data=0xDEADBEEF; stall_o high for the whole access.
- Byte store, post-indexed with writeback: base=0x203, addr_final=0x207, rn=4, data=0xAB -> dmem_addr=0x200, be=4'b1000, wdata=0xABABABAB, we=1; after ack, wb rd=4 data=0x207.
- Byte load, pre-indexed, writeback: ea=0x302, rdata=0x11223344, rd=1, rn=5 -> wb rd=1 data=0x22; next cycle wb rd=5 data=0x302. Same case with rn=rd=1 -> single wb of 0x22.
- Reset asserted in REQ before ack -> next edge dmem_req=0, stall_o=0, no wb_valid; a late ack is ignored.
- MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack -> mem_fault pulses after 4 REQ cycles, no writeback, IDLE.
